// File: rtl/dot_product_acc_if.sv
// dot_product_acc_if: product-in / result-out handshake bundle for dot_product_acc.
//
// Parameters
//   PW  product width (multiplier output)
//   AW  accumulator / result width
//
// Signals
//   in_valid   upstream has a product on in_prod
//   in_ready   accumulator can take a product this cycle
//   in_prod    unsigned product
//   out_valid  out_sum/out_ovf carry a result
//   out_ready  downstream takes the result this cycle
//   out_sum    dot-product result
//   out_ovf    the result overflowed AW bits
//
// Modports
//   master  the environment side: feeds products and consumes results
//   slave   the accumulator side
interface dot_product_acc_if #(
  parameter int unsigned PW = 32,
  parameter int unsigned AW = 40
);

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf
  );

endinterface

// File: rtl/dot_product_acc.sv
// dot_product_acc: sums LEN consecutive unsigned products from the 16x16 Wallace
// multiplier into one dot-product result and holds it until the consumer takes it.
//
// Parameters
//   PW   product width, must match the multiplier output (default 32)
//   AW   accumulator/result width, AW >= PW (default 40)
//   LEN  products per result, LEN >= 2 (default 8)
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   clr   synchronous abort of the running accumulation; last result is kept
//   bus   dot_product_acc_if slave modport (in_valid/in_ready/in_prod,
//         out_valid/out_ready/out_sum/out_ovf)
//
// Configuration
//   DOTACC_SAT_EN  when defined, overflowing sums clamp to 2^AW-1 and stay clamped
//                  until the result is produced; otherwise sums wrap modulo 2^AW.
//                  out_ovf flags overflow in both builds.
module dot_product_acc #(
  parameter int unsigned PW  = 32,
  parameter int unsigned AW  = 40,
  parameter int unsigned LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  dot_product_acc_if.slave       bus
);

  localparam int unsigned CW = $clog2(LEN);
  localparam int unsigned SW = AW + 1;
  localparam logic [CW-1:0] LastCnt = CW'(LEN - 1);

  typedef enum logic [0:0] {
    StAcc  = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic          out_ovf_q, out_ovf_d;

  logic          in_ready;
  logic          accept;
  logic [SW-1:0] sum_ext;
  logic          carry;
  logic [AW-1:0] sum_res;

  // Ready depends on state alone, so it never combinationally follows in_valid.
  assign in_ready = (state_q == StAcc);
  assign accept   = bus.in_valid & in_ready;

  // One extra bit so the carry out of bit AW-1 is visible as overflow.
  assign sum_ext = {1'b0, acc_q} + SW'(bus.in_prod);
  assign carry   = sum_ext[AW];

`ifdef DOTACC_SAT_EN
  // An earlier overflow keeps the sum pinned at full scale for the rest of the result.
  assign sum_res = (carry | ovf_acc_q) ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
  assign sum_res = sum_ext[AW-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (clr) begin
      // Abort drops any product offered in the same cycle; the last result stays visible.
      acc_d       = '0;
      cnt_d       = '0;
      ovf_acc_d   = 1'b0;
      out_valid_d = 1'b0;
      state_d     = StAcc;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            if (cnt_q == LastCnt) begin
              out_sum_d   = sum_res;
              out_ovf_d   = ovf_acc_q | carry;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_acc_d   = 1'b0;
              state_d     = StHold;
            end else begin
              acc_d     = sum_res;
              cnt_d     = cnt_q + CW'(1);
              ovf_acc_d = ovf_acc_q | carry;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StAcc;
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_product_acc.sv
module tb_dot_product_acc;

  logic clk;
  logic rst;
  logic clr;
  logic clr34;

  int n_checks;
  int n_fail;

  dot_product_acc_if #(.PW(32), .AW(40)) bus0 ();
  dot_product_acc_if #(.PW(32), .AW(34)) bus34 ();

  dot_product_acc #(.PW(32), .AW(40), .LEN(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus0.slave)
  );

  dot_product_acc #(.PW(32), .AW(34), .LEN(8)) u_dut34 (
    .clk (clk),
    .rst (rst),
    .clr (clr34),
    .bus (bus34.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product to the 40-bit instance and return just after it is accepted.
  task automatic push(input logic [31:0] p);
    int t;
    t = 0;
    bus0.in_valid = 1'b1;
    bus0.in_prod  = p;
    while (!bus0.in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!bus0.in_ready) check_eq("push_timeout", 64'(bus0.in_ready), 64'd1);
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    clr = 1'b0;
    clr34 = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_prod   = '0;
    bus0.out_ready = 1'b0;
    bus34.in_valid  = 1'b0;
    bus34.in_prod   = '0;
    bus34.out_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    check_eq("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check_eq("rst_out_sum", 64'(bus0.out_sum), 64'd0);
    check_eq("rst_out_ovf", 64'(bus0.out_ovf), 64'd0);
    check_eq("rst34_out_sum", 64'(bus34.out_sum), 64'd0);
    rst = 1'b0;

    // 2: products 1..8 back to back
    for (int i = 1; i <= 8; i++) begin
      push(32'(i));
      if (i == 7) check_eq("t2_not_early", 64'(bus0.out_valid), 64'd0);
    end
    check_eq("t2_out_valid", 64'(bus0.out_valid), 64'd1);
    check_eq("t2_out_sum", 64'(bus0.out_sum), 64'd36);
    check_eq("t2_out_ovf", 64'(bus0.out_ovf), 64'd0);
    check_eq("t2_in_ready", 64'(bus0.in_ready), 64'd0);

    // 3: hold with out_ready low, in_valid toggling
    bus0.in_prod = 32'd99;
    for (int i = 0; i < 10; i++) begin
      bus0.in_valid = (i % 2 == 0);
      tick();
      check_eq("t3_hold_sum", 64'(bus0.out_sum), 64'd36);
      check_eq("t3_hold_valid", 64'(bus0.out_valid), 64'd1);
    end
    bus0.in_valid = 1'b0;
    drain();
    check_eq("t3_out_valid", 64'(bus0.out_valid), 64'd0);
    check_eq("t3_in_ready", 64'(bus0.in_ready), 64'd1);
    check_eq("t3_sum_kept", 64'(bus0.out_sum), 64'd36);

    // 4: 0x10 x8 with idle gaps
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3) + 1; g++) tick();
      push(32'h10);
    end
    check_eq("t4_out_sum", 64'(bus0.out_sum), 64'h80);
    check_eq("t4_out_ovf", 64'(bus0.out_ovf), 64'd0);
    check_eq("t4_out_valid", 64'(bus0.out_valid), 64'd1);
    drain();

    // 5a: abort with clr while a product is offered
    for (int i = 0; i < 3; i++) push(32'd7);
    bus0.in_valid = 1'b1;
    bus0.in_prod  = 32'd7;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("t5_clr_out_valid", 64'(bus0.out_valid), 64'd0);
    check_eq("t5_clr_sum_kept", 64'(bus0.out_sum), 64'h80);
    for (int i = 0; i < 8; i++) push(32'd2);
    check_eq("t5_clr_out_sum", 64'(bus0.out_sum), 64'd16);
    drain();

    // 5b: same with rst
    for (int i = 0; i < 3; i++) push(32'd7);
    bus0.in_valid = 1'b1;
    bus0.in_prod  = 32'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("t5_rst_out_sum", 64'(bus0.out_sum), 64'd0);
    for (int i = 0; i < 8; i++) push(32'd2);
    check_eq("t5_rst_out_sum16", 64'(bus0.out_sum), 64'd16);
    check_eq("t5_rst_out_valid", 64'(bus0.out_valid), 64'd1);

    // clr in HOLD drops valid but keeps the result
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t5_hold_clr_valid", 64'(bus0.out_valid), 64'd0);
    check_eq("t5_hold_clr_ready", 64'(bus0.in_ready), 64'd1);
    check_eq("t5_hold_clr_sum", 64'(bus0.out_sum), 64'd16);

    // 6: AW=34 overflow
    bus34.in_valid = 1'b1;
    bus34.in_prod  = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) tick();
    bus34.in_valid = 1'b0;
    check_eq("t6_out_valid", 64'(bus34.out_valid), 64'd1);
`ifdef DOTACC_SAT_EN
    check_eq("t6_out_sum", 64'(bus34.out_sum), 64'h3_FFFF_FFFF);
`else
    check_eq("t6_out_sum", 64'(bus34.out_sum), 64'h3_FFFF_FFF8);
`endif
    check_eq("t6_out_ovf", 64'(bus34.out_ovf), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
